// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the memory-mapped UART peripheral:
//   - register offsets relative to BASE_ADDR (TXD, RXD, CON)
//   - CON register bit positions
//   - the 2-bit serial FSM state type used by both the TX and RX engines
// Optional build macro used by the peripheral: UART_LOOPBACK_EN.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam logic [31:0] TXD_OFS = 32'd0;
  localparam logic [31:0] RXD_OFS = 32'd4;
  localparam logic [31:0] CON_OFS = 32'd8;

  localparam int CON_TX_IRQ_EN = 0;
  localparam int CON_RX_IRQ_EN = 1;
  localparam int CON_TX_DONE   = 2;
  localparam int CON_RX_DONE   = 3;
  localparam int CON_TX_BUSY   = 4;
  localparam int CON_FRAME_ERR = 5;
  localparam int CON_LOOPBACK  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_peripheral_if.sv
// -----------------------------------------------------------------------------
// uart_peripheral_if
// MEM-stage load/store bus between the CPU (master) and the UART (slave).
//   i_address    : byte address from the ALU result
//   i_read       : load strobe
//   i_write      : store strobe
//   i_write_data : store data
//   o_read_data  : combinational read data, 0 on a miss or when not reading
//   o_hit        : address matches one of the UART registers exactly
// -----------------------------------------------------------------------------
interface uart_peripheral_if;
  logic [31:0] i_address;
  logic        i_read;
  logic        i_write;
  logic [31:0] i_write_data;
  logic [31:0] o_read_data;
  logic        o_hit;

  modport master (
    output i_address, i_read, i_write, i_write_data,
    input  o_read_data, o_hit
  );

  modport slave (
    input  i_address, i_read, i_write, i_write_data,
    output o_read_data, o_hit
  );
endinterface

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// 8N1 receiver: 2-flop synchroniser, start-bit qualification at half a bit
// period, then one sample per bit period (mid-bit), LSB first.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   rx_i       : serial input, asynchronous to clk
//   byte_o     : last assembled byte (valid when done_o pulses)
//   done_o     : 1-cycle pulse, stop bit sampled high
//   err_o      : 1-cycle pulse, stop bit sampled low (framing error)
// -----------------------------------------------------------------------------
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIVISOR = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int            CW       = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIVISOR / 2 - 1);

  logic [1:0]    sync_q;
  logic          rx_s;
  logic          rx_prev_q;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;

  assign rx_s = sync_q[1];

  // Synchroniser flops idle high so a released reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      rx_prev_q <= rx_s;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Half a bit in: a line that is high again was only a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: pulses coincide with the stop-bit sample.
  always_comb begin
    byte_o = shift_q;
    done_o = 1'b0;
    err_o  = 1'b0;
    if (state_q == STOP && cnt_q == CNT_LAST) begin
      done_o = rx_s;
      err_o  = ~rx_s;
    end
  end

endmodule

// File: rtl/uart_peripheral.sv
// -----------------------------------------------------------------------------
// uart_peripheral
// Memory-mapped 8N1 UART responder on the CPU MEM-stage load/store bus.
// Registers: TXD @BASE_ADDR, RXD @BASE_ADDR+4, CON @BASE_ADDR+8.
//   CON: [0] tx_irq_en, [1] rx_irq_en, [2] tx_done, [3] rx_done,
//        [4] tx_busy (RO), [5] frame_err, [6] loopback (only with
//        UART_LOOPBACK_EN defined; otherwise reads 0).
//   Reading CON returns the current value and clears [2],[3],[5] at the edge;
//   a flag being set in the same cycle takes priority over the clear.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : uart_peripheral_if.slave (address/read/write/data/hit)
//   i_uart_rx  : serial input (asynchronous)
//   o_uart_tx  : serial output, idle high
//   o_irq      : (tx_irq_en & tx_done) | (rx_irq_en & rx_done)
// Build macro: UART_LOOPBACK_EN enables internal TX->RX loopback via CON[6].
// -----------------------------------------------------------------------------
module uart_peripheral
  import uart_pkg::*;
#(
  parameter int          CLK_FREQ  = 100_000_000,
  parameter int          BAUD      = 9600,
  parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
  input  logic             clk,
  input  logic             reset,
  uart_peripheral_if.slave bus,
  input  logic             i_uart_rx,
  output logic             o_uart_tx,
  output logic             o_irq
);

  localparam int            DIVISOR  = CLK_FREQ / BAUD;
  localparam int            CW       = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);

  localparam int SEL_TXD = 0;
  localparam int SEL_RXD = 1;
  localparam int SEL_CON = 2;
  localparam logic [31:0] REG_OFS [3] = '{TXD_OFS, RXD_OFS, CON_OFS};

  // ---------------------------------------------------------------------------
  // Address decode: exact word matches only
  // ---------------------------------------------------------------------------
  logic [2:0] sel;
  for (genvar gi = 0; gi < 3; gi++) begin : g_decode
    assign sel[gi] = (bus.i_address == BASE_ADDR + REG_OFS[gi]);
  end

  logic wr_txd, wr_con, rd_con;
  assign wr_txd = sel[SEL_TXD] & bus.i_write;
  assign wr_con = sel[SEL_CON] & bus.i_write;
  assign rd_con = sel[SEL_CON] & bus.i_read;
  assign bus.o_hit = |sel;

  logic unused_wdata;
  assign unused_wdata = ^bus.i_write_data[31:8];

  // ---------------------------------------------------------------------------
  // Register file state
  // ---------------------------------------------------------------------------
  logic [7:0] txd_q, txd_d;
  logic [7:0] rxd_q, rxd_d;
  logic [1:0] irq_en_q, irq_en_d;
  logic       tx_done_q, tx_done_d;
  logic       rx_done_q, rx_done_d;
  logic       frame_err_q, frame_err_d;
  logic       loopback;

  // ---------------------------------------------------------------------------
  // TX engine
  // ---------------------------------------------------------------------------
  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic          tx_line_q, tx_line_d;
  logic          tx_end, tx_accept, tx_busy;

  // Last clock of the stop bit; a store in this cycle chains straight into
  // the next frame with no idle gap.
  assign tx_end    = (tx_state_q == STOP) && (tx_cnt_q == CNT_LAST);
  assign tx_accept = wr_txd && ((tx_state_q == IDLE) || tx_end);
  assign tx_busy   = (tx_state_q != IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // Next-state logic
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    case (tx_state_q)
      IDLE: begin
        if (tx_accept) begin
          tx_state_d = START;
          tx_cnt_d   = '0;
        end
      end
      START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_state_d = DATA;
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = STOP;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = tx_accept ? START : IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // Output logic: the line level is registered from the next state so the
  // pin never glitches while the state/index mux settles.
  always_comb begin
    tx_line_d = 1'b1;
    case (tx_state_d)
      START:   tx_line_d = 1'b0;
      DATA:    tx_line_d = txd_d[tx_idx_d];
      default: tx_line_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX path and optional loopback
  // ---------------------------------------------------------------------------
  logic       rx_line;
  logic [7:0] rx_byte;
  logic       rx_done_p, rx_err_p;

`ifdef UART_LOOPBACK_EN
  logic loopback_q, loopback_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loopback_q <= 1'b0;
    end else begin
      loopback_q <= loopback_d;
    end
  end

  assign loopback_d = wr_con ? bus.i_write_data[CON_LOOPBACK] : loopback_q;
  assign loopback   = loopback_q;
  assign rx_line    = loopback_q ? tx_line_q : i_uart_rx;
  assign o_uart_tx  = loopback_q ? 1'b1 : tx_line_q;
`else
  assign loopback  = 1'b0;
  assign rx_line   = i_uart_rx;
  assign o_uart_tx = tx_line_q;
`endif

  uart_rx_core #(
    .DIVISOR (DIVISOR)
  ) u_rx (
    .clk    (clk),
    .reset  (reset),
    .rx_i   (rx_line),
    .byte_o (rx_byte),
    .done_o (rx_done_p),
    .err_o  (rx_err_p)
  );

  // ---------------------------------------------------------------------------
  // Register file update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txd_q       <= '0;
      rxd_q       <= '0;
      irq_en_q    <= '0;
      tx_done_q   <= 1'b0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      txd_q       <= txd_d;
      rxd_q       <= rxd_d;
      irq_en_q    <= irq_en_d;
      tx_done_q   <= tx_done_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Flags: a set event beats a clearing CON read in the same cycle.
  always_comb begin
    txd_d       = tx_accept ? bus.i_write_data[7:0] : txd_q;
    rxd_d       = rx_done_p ? rx_byte : rxd_q;
    irq_en_d    = wr_con ? bus.i_write_data[1:0] : irq_en_q;
    tx_done_d   = tx_end    ? 1'b1 : (rd_con ? 1'b0 : tx_done_q);
    rx_done_d   = rx_done_p ? 1'b1 : (rd_con ? 1'b0 : rx_done_q);
    frame_err_d = rx_err_p  ? 1'b1 : (rd_con ? 1'b0 : frame_err_q);
  end

  // ---------------------------------------------------------------------------
  // Read mux and interrupt
  // ---------------------------------------------------------------------------
  logic [31:0] con_val;
  always_comb begin
    con_val                = '0;
    con_val[CON_TX_IRQ_EN] = irq_en_q[0];
    con_val[CON_RX_IRQ_EN] = irq_en_q[1];
    con_val[CON_TX_DONE]   = tx_done_q;
    con_val[CON_RX_DONE]   = rx_done_q;
    con_val[CON_TX_BUSY]   = tx_busy;
    con_val[CON_FRAME_ERR] = frame_err_q;
    con_val[CON_LOOPBACK]  = loopback;
  end

  always_comb begin
    bus.o_read_data = '0;
    if (bus.i_read) begin
      if (sel[SEL_TXD]) begin
        bus.o_read_data = {24'd0, txd_q};
      end else if (sel[SEL_RXD]) begin
        bus.o_read_data = {24'd0, rxd_q};
      end else if (sel[SEL_CON]) begin
        bus.o_read_data = con_val;
      end
    end
  end

  assign o_irq = (irq_en_q[0] & tx_done_q) | (irq_en_q[1] & rx_done_q);

endmodule

// File: tb/tb_uart_peripheral.sv
// -----------------------------------------------------------------------------
// tb_uart_peripheral
// Self-checking bench for uart_peripheral with CLK_FREQ=16, BAUD=1 (16 clocks
// per bit). Expected register contents come from a small register-level model
// (last byte sent/received, enables, sticky flags); expected serial waveforms
// are built from the byte value as {stop, data, start}.
// -----------------------------------------------------------------------------
module tb_uart_peripheral;

  localparam int          DIV   = 16;
  localparam logic [31:0] BASE  = 32'h40000018;
  localparam logic [31:0] A_TXD = BASE;
  localparam logic [31:0] A_RXD = BASE + 32'd4;
  localparam logic [31:0] A_CON = BASE + 32'd8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_uart_rx = 1'b1;
  logic o_uart_tx;
  logic o_irq;

  uart_peripheral_if bus();

  uart_peripheral #(
    .CLK_FREQ  (16),
    .BAUD      (1),
    .BASE_ADDR (BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .i_uart_rx (i_uart_rx),
    .o_uart_tx (o_uart_tx),
    .o_irq     (o_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model of the programmer-visible state
  logic [7:0] m_txd, m_rxd;
  logic [1:0] m_en;
  logic       m_txdone, m_rxdone, m_err;

  function automatic logic [31:0] exp_con(input logic busy);
    return {26'd0, m_err, busy, m_rxdone, m_txdone, m_en};
  endfunction

  function automatic logic exp_irq();
    return (m_en[0] & m_txdone) | (m_en[1] & m_rxdone);
  endfunction

  task automatic model_reset();
    m_txd = 8'd0; m_rxd = 8'd0; m_en = 2'd0;
    m_txdone = 1'b0; m_rxdone = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_con_read();
    m_txdone = 1'b0; m_rxdone = 1'b0; m_err = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.i_address = a; bus.i_write_data = d; bus.i_write = 1'b1;
    @(negedge clk);
    bus.i_write = 1'b0; bus.i_address = 32'd0; bus.i_write_data = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    @(negedge clk);
    bus.i_address = a; bus.i_read = 1'b1;
    #1;
    d = bus.o_read_data;
    h = bus.o_hit;
    @(negedge clk);
    bus.i_read = 1'b0; bus.i_address = 32'd0;
  endtask

  // Samples the TX line once per clock for one 10-bit frame, starting at the
  // current negedge (first clock of the start bit).
  task automatic watch_frame(input logic [7:0] b, input string tag);
    logic [9:0]  bits;
    logic [15:0] got;
    logic [15:0] want;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int s = 0; s < DIV; s++) begin
        got[s] = o_uart_tx;
        @(negedge clk);
      end
      want = {16{bits[k]}};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s byte=%02h bit%0d: line=%04h expected=%04h", tag, b, k, got, want);
      end
    end
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      i_uart_rx = bits[k];
      repeat (DIV) @(negedge clk);
    end
    i_uart_rx = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] d;
    logic        h;
    model_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (o_uart_tx !== 1'b1 || o_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins: tx=%b irq=%b expected tx=1 irq=0", o_uart_tx, o_irq);
    end
    reset = 1'b0;
    bus_read(A_CON, d, h);
    checks++;
    if (d !== 32'd0 || h !== 1'b1) begin
      errors++;
      $display("FAIL reset_con: data=%08h hit=%b expected 00000000 hit=1", d, h);
    end
    bus_read(A_TXD, d, h);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_txd: data=%08h expected 00000000", d); end
    bus_read(A_RXD, d, h);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_rxd: data=%08h expected 00000000", d); end
    $display("reset: done");
  endtask

  task automatic test_decode();
    logic [31:0] d, exp;
    logic        h;
    logic [31:0] miss [3];
    miss[0] = BASE + 32'd1;
    miss[1] = BASE + 32'd12;
    miss[2] = BASE - 32'd4;
    for (int i = 0; i < 3; i++) begin
      bus_write(miss[i], $urandom());
      bus_read(miss[i], d, h);
      checks++;
      if (d !== 32'd0 || h !== 1'b0) begin
        errors++;
        $display("FAIL decode_miss addr=%08h: data=%08h hit=%b expected 0/0", miss[i], d, h);
      end
    end
    // Missed stores must not have started a frame or touched CON.
    exp = exp_con(1'b0);
    bus_read(A_CON, d, h);
    model_con_read();
    checks++;
    if (d !== exp) begin errors++; $display("FAIL decode_con_after_miss: data=%08h expected %08h", d, exp); end
    // Hit without a read strobe returns 0.
    @(negedge clk);
    bus.i_address = A_RXD;
    #1;
    checks++;
    if (bus.o_read_data !== 32'd0 || bus.o_hit !== 1'b1) begin
      errors++;
      $display("FAIL decode_noread: data=%08h hit=%b expected 0/1", bus.o_read_data, bus.o_hit);
    end
    bus.i_address = 32'd0;
    // CON write only changes the enables.
    bus_write(A_CON, 32'hFFFF_FFFF);
    m_en = 2'b11;
    exp = exp_con(1'b0);
    bus_read(A_CON, d, h);
    model_con_read();
    checks++;
    if (d !== exp) begin errors++; $display("FAIL decode_con_write: data=%08h expected %08h", d, exp); end
    bus_write(A_CON, 32'd0);
    m_en = 2'b00;
    $display("decode: done");
  endtask

  task automatic test_tx();
    logic [31:0] d, exp;
    logic        h;
    logic [7:0]  b, junk;
    for (int n = 0; n < 3; n++) begin
      b = (n == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      junk = (n == 0) ? 8'h3C : ~b;
      if (n == 2) begin
        bus_write(A_CON, 32'd1);
        m_en = 2'b01;
      end
      bus_write(A_TXD, {8'($urandom()), 16'd0, b});
      m_txd = b;
      fork
        watch_frame(b, "tx_frame");
        begin
          repeat (40) @(negedge clk);
          exp = exp_con(1'b1);
          bus_read(A_CON, d, h);
          model_con_read();
          checks++;
          if (d !== exp) begin errors++; $display("FAIL tx_busy_con: data=%08h expected %08h", d, exp); end
          bus_write(A_TXD, {24'd0, junk});
          bus_read(A_TXD, d, h);
          checks++;
          if (d !== {24'd0, m_txd}) begin
            errors++;
            $display("FAIL tx_write_while_busy: txd=%08h expected %08h", d, {24'd0, m_txd});
          end
        end
      join
      m_txdone = 1'b1;
      checks++;
      if (o_irq !== exp_irq()) begin
        errors++;
        $display("FAIL tx_irq: irq=%b expected %b", o_irq, exp_irq());
      end
      exp = exp_con(1'b0);
      bus_read(A_CON, d, h);
      model_con_read();
      checks++;
      if (d !== exp) begin errors++; $display("FAIL tx_done_con: data=%08h expected %08h", d, exp); end
      checks++;
      if (o_irq !== 1'b0) begin errors++; $display("FAIL tx_irq_clear: irq=%b expected 0", o_irq); end
      $display("tx: byte=%02h sent", b);
    end
    bus_write(A_CON, 32'd0);
    m_en = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, exp;
    logic        h;
    logic [7:0]  b1, b2;
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    bus_write(A_TXD, {24'd0, b1});
    fork
      begin
        watch_frame(b1, "b2b_first");
        watch_frame(b2, "b2b_second");
      end
      begin
        // Store lands on the last clock of the first stop bit.
        repeat (DIV * 10 - 2) @(negedge clk);
        bus_write(A_TXD, {24'd0, b2});
      end
    join
    m_txd = b2;
    m_txdone = 1'b1;
    bus_read(A_TXD, d, h);
    checks++;
    if (d !== {24'd0, m_txd}) begin errors++; $display("FAIL b2b_txd: data=%08h expected %08h", d, {24'd0, m_txd}); end
    exp = exp_con(1'b0);
    bus_read(A_CON, d, h);
    model_con_read();
    checks++;
    if (d !== exp) begin errors++; $display("FAIL b2b_con: data=%08h expected %08h", d, exp); end
    $display("back_to_back: bytes=%02h,%02h", b1, b2);
  endtask

  task automatic test_rx();
    logic [31:0] d, exp;
    logic        h;
    logic [7:0]  b;
    bus_write(A_CON, 32'd2);
    m_en = 2'b10;
    for (int n = 0; n < 3; n++) begin
      b = (n == 0) ? 8'h5A : 8'($urandom_range(0, 255));
      repeat ($urandom_range(1, 20)) @(negedge clk);
      drive_rx(b, 1'b1);
      m_rxd = b;
      m_rxdone = 1'b1;
      checks++;
      if (o_irq !== exp_irq()) begin errors++; $display("FAIL rx_irq: irq=%b expected %b", o_irq, exp_irq()); end
      bus_read(A_RXD, d, h);
      checks++;
      if (d !== {24'd0, m_rxd}) begin errors++; $display("FAIL rx_data: rxd=%08h expected %08h", d, {24'd0, m_rxd}); end
      exp = exp_con(1'b0);
      bus_read(A_CON, d, h);
      model_con_read();
      checks++;
      if (d !== exp) begin errors++; $display("FAIL rx_con: data=%08h expected %08h", d, exp); end
      checks++;
      if (o_irq !== 1'b0) begin errors++; $display("FAIL rx_irq_clear: irq=%b expected 0", o_irq); end
      $display("rx: byte=%02h received", b);
    end
  endtask

  task automatic test_frame_err();
    logic [31:0] d, exp;
    logic        h;
    logic [7:0]  b;
    b = 8'($urandom_range(0, 255));
    drive_rx(b, 1'b0);
    repeat (DIV) @(negedge clk);
    m_err = 1'b1;
    checks++;
    if (o_irq !== exp_irq()) begin errors++; $display("FAIL ferr_irq: irq=%b expected %b", o_irq, exp_irq()); end
    exp = exp_con(1'b0);
    bus_read(A_CON, d, h);
    model_con_read();
    checks++;
    if (d !== exp) begin errors++; $display("FAIL ferr_con: data=%08h expected %08h", d, exp); end
    bus_read(A_RXD, d, h);
    checks++;
    if (d !== {24'd0, m_rxd}) begin errors++; $display("FAIL ferr_rxd: rxd=%08h expected %08h", d, {24'd0, m_rxd}); end
    $display("frame_err: byte=%02h with low stop", b);
    // Short low glitch on an idle line
    i_uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    i_uart_rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    exp = exp_con(1'b0);
    bus_read(A_CON, d, h);
    model_con_read();
    checks++;
    if (d !== exp) begin errors++; $display("FAIL glitch_con: data=%08h expected %08h", d, exp); end
    // Receiver still works after the glitch
    b = 8'($urandom_range(0, 255));
    drive_rx(b, 1'b1);
    m_rxd = b;
    m_rxdone = 1'b1;
    bus_read(A_RXD, d, h);
    checks++;
    if (d !== {24'd0, m_rxd}) begin errors++; $display("FAIL glitch_then_rx: rxd=%08h expected %08h", d, {24'd0, m_rxd}); end
    bus_read(A_CON, d, h);
    model_con_read();
    $display("glitch: ignored, then byte=%02h received", b);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    logic        h;
    logic [7:0]  b;
    b = 8'($urandom_range(0, 255));
    bus_write(A_CON, 32'd3);
    bus_write(A_TXD, {24'd0, b});
    repeat (40) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (o_uart_tx !== 1'b1 || o_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pins: tx=%b irq=%b expected tx=1 irq=0", o_uart_tx, o_irq);
    end
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus_read(A_CON, d, h);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_mid_con: data=%08h expected 00000000", d); end
    bus_read(A_TXD, d, h);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_mid_txd: data=%08h expected 00000000", d); end
    b = 8'($urandom_range(0, 255));
    bus_write(A_TXD, {24'd0, b});
    m_txd = b;
    watch_frame(b, "post_reset_frame");
    m_txdone = 1'b1;
    bus_read(A_CON, d, h);
    checks++;
    if (d !== exp_con(1'b0)) begin errors++; $display("FAIL post_reset_con: data=%08h expected %08h", d, exp_con(1'b0)); end
    model_con_read();
    $display("reset_midframe: clean frame byte=%02h", b);
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    bus.i_address    = 32'd0;
    bus.i_read       = 1'b0;
    bus.i_write      = 1'b0;
    bus.i_write_data = 32'd0;
    test_reset();
    test_decode();
    test_tx();
    test_back_to_back();
    test_rx();
    test_frame_err();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
